mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous data/instruction SRAM between the RV32 core's instruction-fetch port and its load/store port.
- Arbitrates per cycle, drives the SRAM, and routes read data back to the correct requester one cycle later.
- Data port has fixed priority, with a starvation guard so fetch always makes progress.
- Sits between rv32 core and the unified memory; the core stalls on missing grant.

---
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store, data first with a fetch starvation guard.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;

  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       fetch_forced;

  // Grants are forced low during reset so nothing reaches the SRAM.
  always_comb begin
    fetch_forced = i_req && (starve_cnt == SMAX);
    d_gnt        = rst_n & d_req & ~fetch_forced;
    i_gnt        = rst_n & i_req & ~d_gnt;
    mem_en       = i_gnt | d_gnt;
    mem_we       = d_gnt & d_we;
    mem_addr     = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
    mem_wdata    = d_gnt ? d_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      if (i_gnt)             owner <= OWN_FETCH;
      else if (d_gnt && !d_we) owner <= OWN_LOAD;
      else                   owner <= OWN_NONE;

      if (!i_req || i_gnt)                   starve_cnt <= '0;
      else if (d_gnt && starve_cnt != SMAX)  starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign i_rvalid = (owner == OWN_FETCH);
  assign d_rvalid = (owner == OWN_LOAD);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (i_req && d_req)  conflict_cnt <= conflict_cnt + 32'd1;
      if (i_req && !i_gnt) stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants checked inline per scenario, read returns popped by a monitor.
module tb_mem_port_arbiter;
  localparam int AW = 10, DW = 32, SMAX = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   conflict_cnt, stall_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
`ifdef ARB_PERF_CNT_EN
    .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt),
`endif
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int a);
    if (a < 4)     return 32'h0000_0013;
    if (a == 'h20) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(a);
  endfunction

  // SRAM model, loaded on the first edge; ref_mem is the bench's own record of contents.
  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int a = 0; a < (1<<AW); a++) sram[a] <= init_val(a);
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  typedef struct { bit fetch; logic [DW-1:0] data; int cyc; } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.fetch) begin
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== e.data) begin
          n_fail++;
          $display("FAIL fetch_return: i_rvalid=%b d_rvalid=%b i_rdata=%h, required 1 0 %h", i_rvalid, d_rvalid, i_rdata, e.data);
        end
      end else begin
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== e.data) begin
          n_fail++;
          $display("FAIL load_return: d_rvalid=%b i_rvalid=%b d_rdata=%h, required 1 0 %h", d_rvalid, i_rvalid, d_rdata, e.data);
        end
      end
    end else begin
      n_checks++;
      if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_rvalid: i_rvalid=%b d_rvalid=%b, required 0 0", i_rvalid, d_rvalid);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; i_addr = 10'h005; d_addr = 10'h006; d_wdata = '1;
    #2;
    n_checks++;
    if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b%b en=%b we=%b rv=%b%b addr=%h wdata=%h, required all 0",
               i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid, mem_addr, mem_wdata);
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1; i_req = 1'b1; i_addr = 10'h010; #1;
    n_checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 10'h010) begin
      n_fail++;
      $display("FAIL pre_reset_fetch: i_gnt=%b d_gnt=%b addr=%h, required 1 0 010", i_gnt, d_gnt, mem_addr);
    end
    @(posedge clk); #1; i_req = 1'b0; rst_n = 1'b0; #1;
    n_checks++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_gnt !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_read: i_rvalid=%b d_rvalid=%b i_gnt=%b en=%b, required 0", i_rvalid, d_rvalid, i_gnt, mem_en);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; i_req = 1'b1; i_addr = 10'h010; #1;
    n_checks++;
    if (i_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'h010) begin
      n_fail++;
      $display("FAIL post_reset_fetch: i_gnt=%b en=%b addr=%h, required 1 1 010", i_gnt, mem_en, mem_addr);
    end
    sb.push_back('{1'b1, ref_mem[10'h010], cyc});
    @(posedge clk); #1; i_req = 1'b0;
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1; i_req = 1'b1; i_addr = AW'(k); #1;
      n_checks++;
      if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== AW'(k) || mem_we !== 1'b0 || mem_wdata !== '0) begin
        n_fail++;
        $display("FAIL fetch_grant[%0d]: i_gnt=%b d_gnt=%b addr=%h we=%b wdata=%h, required 1 0 %h 0 0",
                 k, i_gnt, d_gnt, mem_addr, mem_we, mem_wdata, AW'(k));
      end
      sb.push_back('{1'b1, 32'h0000_0013, cyc});
    end
    @(posedge clk); #1; i_req = 1'b0;
  endtask

  task automatic test_conflict();
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 10'h004; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020; #1;
    n_checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_addr !== 10'h020) begin
      n_fail++;
      $display("FAIL conflict_data_first: d_gnt=%b i_gnt=%b addr=%h, required 1 0 020", d_gnt, i_gnt, mem_addr);
    end
    sb.push_back('{1'b0, 32'hDEAD_BEEF, cyc});
    @(posedge clk); #1; d_req = 1'b0; #1;
    n_checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 10'h004) begin
      n_fail++;
      $display("FAIL conflict_fetch_next: i_gnt=%b d_gnt=%b addr=%h, required 1 0 004", i_gnt, d_gnt, mem_addr);
    end
    sb.push_back('{1'b1, ref_mem[10'h004], cyc});
    @(posedge clk); #1; i_req = 1'b0;
  endtask

  task automatic test_starvation();
    int sc = 0;
    bit exp_f;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] c0 = '0, s0 = '0;
`endif
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 10'h008; d_req = 1'b1; d_we = 1'b0; d_addr = AW'(10'h100 + k); #1;
`ifdef ARB_PERF_CNT_EN
      if (k == 0) begin c0 = conflict_cnt; s0 = stall_cnt; end
`endif
      exp_f = (sc == SMAX);
      n_checks++;
      if (i_gnt !== exp_f || d_gnt !== !exp_f) begin
        n_fail++;
        $display("FAIL starve_pattern[%0d]: i_gnt=%b d_gnt=%b, required %b %b", k, i_gnt, d_gnt, exp_f, !exp_f);
      end
      if (exp_f) sb.push_back('{1'b1, ref_mem[10'h008], cyc});
      else       sb.push_back('{1'b0, ref_mem[10'h100 + k], cyc});
      sc = exp_f ? 0 : ((sc < SMAX) ? sc + 1 : sc);
    end
    @(posedge clk); #1;
`ifdef ARB_PERF_CNT_EN
    n_checks++;
    if (conflict_cnt - c0 !== 32'd10 || stall_cnt - s0 !== 32'd8) begin
      n_fail++;
      $display("FAIL perf_counters: conflict=%0d stall=%0d, required 10 8", conflict_cnt - c0, stall_cnt - s0);
    end
`endif
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_store_load();
    @(posedge clk); #1; d_req = 1'b1; d_we = 1'b1; d_addr = 10'h040; d_wdata = 32'h1234_5678; #1;
    n_checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h040 || mem_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL store_drive: d_gnt=%b we=%b addr=%h wdata=%h, required 1 1 040 12345678", d_gnt, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[10'h040] = 32'h1234_5678;
    @(posedge clk); #1; d_we = 1'b0; #1;
    n_checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL load_after_store: d_gnt=%b we=%b en=%b, required 1 0 1", d_gnt, mem_we, mem_en);
    end
    sb.push_back('{1'b0, 32'h1234_5678, cyc});
    @(posedge clk); #1; d_req = 1'b0; #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_drive: we=%b en=%b, required 0 0", mem_we, mem_en);
    end
    @(posedge clk); #1; d_req = 1'b1; d_we = 1'b1; d_addr = 10'h044; d_wdata = 32'h0BAD_F00D; #1;
    n_checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL store2_drive: d_gnt=%b we=%b, required 1 1", d_gnt, mem_we);
    end
    ref_mem[10'h044] = 32'h0BAD_F00D;
    @(posedge clk); #1; d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 10'h044; #1;
    n_checks++;
    if (i_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h044) begin
      n_fail++;
      $display("FAIL fetch_after_store: i_gnt=%b we=%b addr=%h, required 1 0 044", i_gnt, mem_we, mem_addr);
    end
    sb.push_back('{1'b1, 32'h0BAD_F00D, cyc});
    @(posedge clk); #1; i_req = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < (1<<AW); a++) ref_mem[a] = init_val(a);
    test_reset();
    test_fetch_only();
    test_conflict();
    test_starvation();
    test_store_load();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_returns: %0d outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
